fifo_ctrl_dualport: RTL and testbench



---
 rtl/fifo_ctrl_dualport.sv | 105 ++++++++++
 tb/tb_fifo_ctrl_dualport.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_dualport.sv
// FIFO pointer/occupancy controller in front of a SyncRAMDualPort array (port A writes, port B FWFT read).
// Optional high-water mark and drop counter are built only when FIFO_CTRL_STATS_EN is defined.
module fifo_ctrl_dualport #(
  parameter int unsigned ADDR_WIDTH        = 4,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned ALMOST_FULL_LEVEL = (1 << ADDR_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pushValid,
  input  logic [DATA_WIDTH-1:0] pushData,
  output logic                  pushReady,
  output logic                  popValid,
  output logic [DATA_WIDTH-1:0] popData,
  input  logic                  popReady,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  almostFull,
  output logic [ADDR_WIDTH-1:0] ramAddressA,
  output logic                  ramWriteA,
  output logic [DATA_WIDTH-1:0] ramWriteDataA,
  output logic [ADDR_WIDTH-1:0] ramAddressB,
  output logic                  ramWriteB,
  output logic [DATA_WIDTH-1:0] ramWriteDataB,
  input  logic [DATA_WIDTH-1:0] ramReadDataB,
  output logic [ADDR_WIDTH:0]   peakLevel,
  output logic [15:0]           dropCount
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtrNext;
  logic [PTR_W-1:0] rdPtrNext;
  logic             pushFire;
  logic             popFire;

  // Status flags depend only on registered pointers; the MSB is the wrap bit.
  assign empty      = (wrPtr == rdPtr);
  assign full       = (wrPtr[ADDR_WIDTH] != rdPtr[ADDR_WIDTH]) &&
                      (wrPtr[ADDR_WIDTH-1:0] == rdPtr[ADDR_WIDTH-1:0]);
  assign level      = wrPtr - rdPtr;
  assign almostFull = (level >= PTR_W'(ALMOST_FULL_LEVEL));

  // Gating with rst_n keeps the RAM write strobe quiet while reset is held.
  assign pushReady = !full && rst_n;
  assign popValid  = !empty;
  assign popData   = ramReadDataB;

  assign pushFire = pushValid && pushReady;
  assign popFire  = popValid && popReady;

  assign wrPtrNext = pushFire ? wrPtr + PTR_W'(1) : wrPtr;
  assign rdPtrNext = popFire  ? rdPtr + PTR_W'(1) : rdPtr;

  assign ramAddressA   = wrPtr[ADDR_WIDTH-1:0];
  assign ramWriteA     = pushFire;
  assign ramWriteDataA = pushData;
  assign ramAddressB   = rdPtr[ADDR_WIDTH-1:0];
  assign ramWriteB     = 1'b0;
  assign ramWriteDataB = '0;

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      wrPtr <= wrPtrNext;
      rdPtr <= rdPtrNext;
    end
  end

`ifdef FIFO_CTRL_STATS_EN
  logic [PTR_W-1:0] levelNext;
  logic [PTR_W-1:0] peakReg;
  logic [15:0]      dropReg;

  // Track the post-edge level so the high-water mark moves with the pointers.
  assign levelNext = wrPtrNext - rdPtrNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peakReg <= '0;
      dropReg <= '0;
    end else begin
      if (levelNext > peakReg) begin
        peakReg <= levelNext;
      end
      if (pushValid && !pushReady && (dropReg != 16'hFFFF)) begin
        dropReg <= dropReg + 16'd1;
      end
    end
  end

  assign peakLevel = peakReg;
  assign dropCount = dropReg;
`else
  assign peakLevel = '0;
  assign dropCount = '0;
`endif

endmodule

// File: tb/tb_fifo_ctrl_dualport.sv
// Directed bench for fifo_ctrl_dualport (depth 4, almost-full at 2) with a behavioural RAM model.
module tb_fifo_ctrl_dualport;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst_n;
  logic          pushValid;
  logic [DW-1:0] pushData;
  logic          pushReady;
  logic          popValid;
  logic [DW-1:0] popData;
  logic          popReady;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          almostFull;
  logic [AW-1:0] ramAddressA;
  logic          ramWriteA;
  logic [DW-1:0] ramWriteDataA;
  logic [AW-1:0] ramAddressB;
  logic          ramWriteB;
  logic [DW-1:0] ramWriteDataB;
  logic [DW-1:0] ramReadDataB;
  logic [AW:0]   peakLevel;
  logic [15:0]   dropCount;

  int tests = 0;
  int fails = 0;

  fifo_ctrl_dualport #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ALMOST_FULL_LEVEL(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pushValid(pushValid),
    .pushData(pushData),
    .pushReady(pushReady),
    .popValid(popValid),
    .popData(popData),
    .popReady(popReady),
    .level(level),
    .full(full),
    .empty(empty),
    .almostFull(almostFull),
    .ramAddressA(ramAddressA),
    .ramWriteA(ramWriteA),
    .ramWriteDataA(ramWriteDataA),
    .ramAddressB(ramAddressB),
    .ramWriteB(ramWriteB),
    .ramWriteDataB(ramWriteDataB),
    .ramReadDataB(ramReadDataB),
    .peakLevel(peakLevel),
    .dropCount(dropCount)
  );

  // Storage array: synchronous write on port A, asynchronous read on port B.
  logic [DW-1:0] mem [4];
  always_ff @(posedge clk) begin
    if (ramWriteA) mem[ramAddressA] <= ramWriteDataA;
  end
  assign ramReadDataB = mem[ramAddressB];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pushValid = 1'b1; pushData = 32'hDEAD; popReady = 1'b0;
    step();
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL reset_level got %0d exp 0", level); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", empty); end
    tests++; if (full !== 1'b0 || almostFull !== 1'b0) begin fails++; $display("FAIL reset_full_af got %b%b exp 00", full, almostFull); end
    tests++; if (popValid !== 1'b0) begin fails++; $display("FAIL reset_popValid got %b exp 0", popValid); end
    tests++; if (pushReady !== 1'b0 || ramWriteA !== 1'b0) begin fails++; $display("FAIL reset_pushReady_wr got %b%b exp 00", pushReady, ramWriteA); end
    tests++; if (ramAddressA !== 2'd0 || ramAddressB !== 2'd0) begin fails++; $display("FAIL reset_addr got %0d/%0d exp 0/0", ramAddressA, ramAddressB); end
    tests++; if (ramWriteB !== 1'b0 || ramWriteDataB !== 32'd0) begin fails++; $display("FAIL portB_tie got %b/%0h exp 0/0", ramWriteB, ramWriteDataB); end
    tests++; if (peakLevel !== 3'd0 || dropCount !== 16'd0) begin fails++; $display("FAIL reset_stats got %0d/%0d exp 0/0", peakLevel, dropCount); end
    #2 rst_n = 1'b1; pushValid = 1'b0;
    #1;
    tests++; if (pushReady !== 1'b1) begin fails++; $display("FAIL release_pushReady got %b exp 1", pushReady); end
    step();
  endtask

  task automatic test_fill();
    popReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pushValid = 1'b1; pushData = 32'hA0 + 32'(i);
      #1;
      tests++; if (ramWriteA !== 1'b1 || ramAddressA !== 2'(i)) begin fails++; $display("FAIL fill_write%0d got %b/%0d exp 1/%0d", i, ramWriteA, ramAddressA, i); end
      step();
      tests++; if (level !== 3'(i + 1)) begin fails++; $display("FAIL fill_level%0d got %0d exp %0d", i, level, i + 1); end
      tests++; if (almostFull !== (i >= 1)) begin fails++; $display("FAIL fill_af%0d got %b exp %b", i, almostFull, i >= 1); end
      tests++; if (full !== (i == 3) || pushReady !== (i != 3)) begin fails++; $display("FAIL fill_full%0d got full=%b rdy=%b exp full=%b", i, full, pushReady, i == 3); end
    end
    pushValid = 1'b0;
    popReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (popValid !== 1'b1 || popData !== 32'hA0 + 32'(i)) begin fails++; $display("FAIL drain_data%0d got v=%b %0h exp v=1 %0h", i, popValid, popData, 32'hA0 + 32'(i)); end
      step();
      tests++; if (level !== 3'(3 - i) || empty !== (i == 3)) begin fails++; $display("FAIL drain_level%0d got %0d/%b exp %0d/%b", i, level, empty, 3 - i, i == 3); end
    end
    popReady = 1'b0;
  endtask

  task automatic test_wrap();
    pushValid = 1'b1; pushData = 32'hB0; popReady = 1'b0;
    step();
    popReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pushData = 32'hB1 + 32'(i);
      #1;
      tests++; if (popData !== 32'hB0 + 32'(i)) begin fails++; $display("FAIL wrap_data%0d got %0h exp %0h", i, popData, 32'hB0 + 32'(i)); end
      step();
      tests++; if (level !== 3'd1) begin fails++; $display("FAIL wrap_level%0d got %0d exp 1", i, level); end
    end
    pushValid = 1'b0;
    #1;
    tests++; if (popData !== 32'hBA) begin fails++; $display("FAIL wrap_last got %0h exp ba", popData); end
    step();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL wrap_empty got %b exp 1", empty); end
    popReady = 1'b0;
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) begin
      pushValid = 1'b1; pushData = 32'hC0 + 32'(i);
      step();
    end
    pushData = 32'hC4; popReady = 1'b1;
    #1;
    tests++; if (pushReady !== 1'b0 || ramWriteA !== 1'b0) begin fails++; $display("FAIL fullpop_nopass got %b/%b exp 0/0", pushReady, ramWriteA); end
    tests++; if (popData !== 32'hC0) begin fails++; $display("FAIL fullpop_head got %0h exp c0", popData); end
    step();
    tests++; if (level !== 3'd3 || full !== 1'b0) begin fails++; $display("FAIL fullpop_c1 got %0d/%b exp 3/0", level, full); end
    popReady = 1'b0;
    step();
    tests++; if (level !== 3'd4 || full !== 1'b1) begin fails++; $display("FAIL fullpop_c2 got %0d/%b exp 4/1", level, full); end
    pushValid = 1'b0; popReady = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #1;
      tests++; if (popData !== 32'hC0 + 32'(i)) begin fails++; $display("FAIL fullpop_drain%0d got %0h exp %0h", i, popData, 32'hC0 + 32'(i)); end
      step();
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL fullpop_empty got %b exp 1", empty); end
    popReady = 1'b0;
  endtask

  task automatic test_empty_push();
    pushValid = 1'b1; pushData = 32'h55; popReady = 1'b1;
    #1;
    tests++; if (popValid !== 1'b0) begin fails++; $display("FAIL emptypush_nobypass got %b exp 0", popValid); end
    step();
    pushValid = 1'b0;
    #1;
    tests++; if (popValid !== 1'b1 || popData !== 32'h55) begin fails++; $display("FAIL emptypush_next got %b/%0h exp 1/55", popValid, popData); end
    step();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL emptypush_empty got %b exp 1", empty); end
    popReady = 1'b0;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      pushValid = 1'b1; pushData = 32'h31 + 32'(i);
      step();
    end
    tests++; if (level !== 3'd3) begin fails++; $display("FAIL midrst_pre got %0d exp 3", level); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (level !== 3'd0 || empty !== 1'b1 || popValid !== 1'b0) begin fails++; $display("FAIL midrst_clear got %0d/%b/%b exp 0/1/0", level, empty, popValid); end
    tests++; if (ramWriteA !== 1'b0) begin fails++; $display("FAIL midrst_wr got %b exp 0", ramWriteA); end
    step();
    tests++; if (level !== 3'd0 || ramWriteA !== 1'b0) begin fails++; $display("FAIL midrst_hold got %0d/%b exp 0/0", level, ramWriteA); end
    #2 rst_n = 1'b1; pushData = 32'h11;
    step();
    pushValid = 1'b0; popReady = 1'b1;
    #1;
    tests++; if (popValid !== 1'b1 || popData !== 32'h11) begin fails++; $display("FAIL midrst_pop got %b/%0h exp 1/11", popValid, popData); end
    step();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL midrst_empty got %b exp 1", empty); end
    popReady = 1'b0;
  endtask

  task automatic test_stats();
    logic [15:0] expDrop;
    logic [2:0]  expPeak;
`ifdef FIFO_CTRL_STATS_EN
    expDrop = 16'd5; expPeak = 3'd4;
`else
    expDrop = 16'd0; expPeak = 3'd0;
`endif
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    pushValid = 1'b1; popReady = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pushData = 32'hE0 + 32'(i);
      step();
    end
    pushValid = 1'b0;
    tests++; if (dropCount !== expDrop) begin fails++; $display("FAIL stats_drop got %0d exp %0d", dropCount, expDrop); end
    tests++; if (peakLevel !== expPeak) begin fails++; $display("FAIL stats_peak got %0d exp %0d", peakLevel, expPeak); end
    popReady = 1'b1;
    repeat (4) step();
    popReady = 1'b0;
    tests++; if (empty !== 1'b1 || peakLevel !== expPeak) begin fails++; $display("FAIL stats_peak_hold got %b/%0d exp 1/%0d", empty, peakLevel, expPeak); end
  endtask

  initial begin
    rst_n = 1'b0; pushValid = 1'b0; pushData = '0; popReady = 1'b0;
    test_reset();
    test_fill();
    test_wrap();
    test_full_pop();
    test_empty_push();
    test_mid_reset();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
